// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS output scheduler.
// QOS_STRICT_PRIORITY_EN selects the strict-priority arbiter in qos_scheduler.
package qos_pkg;

  localparam int NUM_BUF     = 4;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX_DEF = 99;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    READ = 2'd2
  } state_t;

endpackage

// File: rtl/qos_stat_counter.sv
// Saturating statistics counter for the VGA stats table.
// Clear wins over a coincident increment.
module qos_stat_counter
  import qos_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/qos_scheduler.sv
// WRR output scheduler and per-buffer statistics for bf1..bf4.
// Define QOS_STRICT_PRIORITY_EN for fixed priority (bf1 highest).
module qos_scheduler
  import qos_pkg::*;
#(
  parameter int W1      = 4,
  parameter int W2      = 3,
  parameter int W3      = 2,
  parameter int W4      = 1,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic       F25MHZ,
  input  logic       rst_n,
  input  logic       slot_tick,
  input  logic       arr_valid,
  input  logic [1:0] arr_id,
  input  logic [3:0] buf_full,
  input  logic [3:0] buf_empty,
  input  logic       rd_ack,
  input  logic       stats_clr,
  output logic [3:0] rd_req,
  output logic       busy,
  output logic [7:0] bf1_dropped,
  output logic [7:0] bf2_dropped,
  output logic [7:0] bf3_dropped,
  output logic [7:0] bf4_dropped,
  output logic [7:0] bf1_total,
  output logic [7:0] bf2_total,
  output logic [7:0] bf3_total,
  output logic [7:0] bf4_total,
  output logic [7:0] bf1_read,
  output logic [7:0] bf2_read,
  output logic [7:0] bf3_read,
  output logic [7:0] bf4_read
);

  state_t     state_q, state_d;
  logic [3:0] rd_req_q, rd_req_d;
  logic       busy_q, busy_d;
  logic       found;
  buf_idx_t   pick;

`ifndef QOS_STRICT_PRIORITY_EN
  localparam logic [NUM_BUF-1:0][3:0] WEIGHT =
    {4'(W4), 4'(W3), 4'(W2), 4'(W1)};

  logic [NUM_BUF-1:0][3:0] credit_q, credit_d;
  buf_idx_t ptr_q, ptr_d;
  buf_idx_t sel_q, sel_d;
  buf_idx_t cand;

  // First non-empty buffer with credit, scanning from ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NUM_BUF; k++) begin
      cand = ptr_q + buf_idx_t'(k);
      if (!found && !buf_empty[cand] &&
          credit_q[cand] != 4'd0) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_BUF - 1; k >= 0; k--) begin
      if (!buf_empty[k]) begin
        found = 1'b1;
        pick  = buf_idx_t'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    rd_req_d = rd_req_q;
`ifndef QOS_STRICT_PRIORITY_EN
    credit_d = credit_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (slot_tick)
          state_d = ARB;
      end
      ARB: begin
        if (found) begin
          rd_req_d = 4'b0001 << pick;
          state_d  = READ;
`ifndef QOS_STRICT_PRIORITY_EN
          sel_d    = pick;
        end else if (!(&buf_empty)) begin
          credit_d = WEIGHT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_ack) begin
          rd_req_d = '0;
          state_d  = IDLE;
`ifndef QOS_STRICT_PRIORITY_EN
          credit_d[sel_q] = credit_q[sel_q] - 4'd1;
          if (credit_q[sel_q] == 4'd1)
            ptr_d = sel_q + 2'd1;
`endif
        end
      end
      default: begin
        state_d  = IDLE;
        rd_req_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge F25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_req_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      busy_q   <= busy_d;
    end
  end

`ifndef QOS_STRICT_PRIORITY_EN
  always_ff @(posedge F25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= WEIGHT;
      ptr_q    <= '0;
      sel_q    <= '0;
    end else begin
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
    end
  end
`endif

  assign rd_req = rd_req_q;
  assign busy   = busy_q;

  logic [NUM_BUF-1:0] tot_inc, drp_inc, rd_inc;

  always_comb begin
    tot_inc = '0;
    drp_inc = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      tot_inc[i] = arr_valid && (arr_id == buf_idx_t'(i));
      drp_inc[i] = tot_inc[i] && buf_full[i];
    end
    rd_inc = {NUM_BUF{rd_ack}} & rd_req_q;
  end

  logic [NUM_BUF-1:0][CNT_W-1:0] dropped, total, rd_cnt;

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_stat
    qos_stat_counter #(
      .CNT_MAX (CNT_W'(CNT_MAX))
    ) u_drp (
      .clk   (F25MHZ),
      .rst_n (rst_n),
      .inc   (drp_inc[i]),
      .clr   (stats_clr),
      .cnt   (dropped[i])
    );
    qos_stat_counter #(
      .CNT_MAX (CNT_W'(CNT_MAX))
    ) u_tot (
      .clk   (F25MHZ),
      .rst_n (rst_n),
      .inc   (tot_inc[i]),
      .clr   (stats_clr),
      .cnt   (total[i])
    );
    qos_stat_counter #(
      .CNT_MAX (CNT_W'(CNT_MAX))
    ) u_rd (
      .clk   (F25MHZ),
      .rst_n (rst_n),
      .inc   (rd_inc[i]),
      .clr   (stats_clr),
      .cnt   (rd_cnt[i])
    );
  end

  assign bf1_dropped = dropped[0];
  assign bf2_dropped = dropped[1];
  assign bf3_dropped = dropped[2];
  assign bf4_dropped = dropped[3];
  assign bf1_total   = total[0];
  assign bf2_total   = total[1];
  assign bf3_total   = total[2];
  assign bf4_total   = total[3];
  assign bf1_read    = rd_cnt[0];
  assign bf2_read    = rd_cnt[1];
  assign bf3_read    = rd_cnt[2];
  assign bf4_read    = rd_cnt[3];

endmodule

// File: tb/tb_qos_scheduler.sv
// Randomized self-checking bench for qos_scheduler.
// Build with QOS_STRICT_PRIORITY_EN to check the strict-priority variant.
module tb_qos_scheduler;

  localparam int W1 = 4;
  localparam int W2 = 3;
  localparam int W3 = 2;
  localparam int W4 = 1;
  localparam int CMAX = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       slot_tick = 1'b0;
  logic       arr_valid = 1'b0;
  logic [1:0] arr_id = 2'd0;
  logic [3:0] buf_full = 4'd0;
  logic [3:0] buf_empty = 4'hf;
  logic       rd_ack = 1'b0;
  logic       stats_clr = 1'b0;
  logic [3:0] rd_req;
  logic       busy;
  logic [7:0] drp [4];
  logic [7:0] tot [4];
  logic [7:0] rdc [4];

  always #5 clk = ~clk;

  qos_scheduler #(
    .W1(W1), .W2(W2), .W3(W3), .W4(W4), .CNT_MAX(CMAX)
  ) dut (
    .F25MHZ      (clk),
    .rst_n       (rst_n),
    .slot_tick   (slot_tick),
    .arr_valid   (arr_valid),
    .arr_id      (arr_id),
    .buf_full    (buf_full),
    .buf_empty   (buf_empty),
    .rd_ack      (rd_ack),
    .stats_clr   (stats_clr),
    .rd_req      (rd_req),
    .busy        (busy),
    .bf1_dropped (drp[0]),
    .bf2_dropped (drp[1]),
    .bf3_dropped (drp[2]),
    .bf4_dropped (drp[3]),
    .bf1_total   (tot[0]),
    .bf2_total   (tot[1]),
    .bf3_total   (tot[2]),
    .bf4_total   (tot[3]),
    .bf1_read    (rdc[0]),
    .bf2_read    (rdc[1]),
    .bf3_read    (rdc[2]),
    .bf4_read    (rdc[3])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: counters, credits, pointer.
  int  m_tot [4];
  int  m_drp [4];
  int  m_rd  [4];
  int  credit [4];
  int  ptr;
  int  weight [4] = '{W1, W2, W3, W4};
  bit  exp_active = 0;
  int  exp_idx = 0;
  bit  rand_en = 0;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_clear_cnt();
    for (int i = 0; i < 4; i++) begin
      m_tot[i] = 0;
      m_drp[i] = 0;
      m_rd[i]  = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear_cnt();
    end else if (stats_clr) begin
      model_clear_cnt();
    end else begin
      if (arr_valid) begin
        m_tot[arr_id] = sat(m_tot[arr_id]);
        if (buf_full[arr_id])
          m_drp[arr_id] = sat(m_drp[arr_id]);
      end
      if (rd_ack && exp_active)
        m_rd[exp_idx] = sat(m_rd[exp_idx]);
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      arr_valid = 1'($urandom_range(0, 1));
      arr_id    = 2'($urandom_range(0, 3));
      buf_full  = 4'($urandom);
      stats_clr = ($urandom_range(0, 39) == 0);
    end
  end

  function automatic int scan(input logic [3:0] emp);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (ptr + k) % 4;
      if (!emp[j] && credit[j] > 0)
        return j;
    end
    return -1;
  endfunction

  task automatic model_pick(input logic [3:0] emp,
                            output int idx, output bit rl);
    idx = -1;
    rl  = 0;
`ifdef QOS_STRICT_PRIORITY_EN
    for (int i = 3; i >= 0; i--)
      if (!emp[i]) idx = i;
`else
    idx = scan(emp);
    if (idx < 0 && emp != 4'hf) begin
      rl = 1;
      for (int i = 0; i < 4; i++) credit[i] = weight[i];
      idx = scan(emp);
    end
`endif
  endtask

  task automatic model_serve(input int idx);
`ifndef QOS_STRICT_PRIORITY_EN
    credit[idx]--;
    if (credit[idx] == 0)
      ptr = (idx + 1) % 4;
`endif
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_bf%0d_total", tag, i + 1), tot[i], m_tot[i]);
      chk($sformatf("%s_bf%0d_drop", tag, i + 1), drp[i], m_drp[i]);
      chk($sformatf("%s_bf%0d_read", tag, i + 1), rdc[i], m_rd[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slot_tick = 0; arr_valid = 0; rd_ack = 0; stats_clr = 0;
    buf_full = 0; buf_empty = 4'hf;
    model_clear_cnt();
    for (int i = 0; i < 4; i++) credit[i] = weight[i];
    ptr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input int id, input logic [3:0] full);
    arr_valid = 1'b1;
    arr_id    = 2'(id);
    buf_full  = full;
    @(posedge clk);
    #1;
    arr_valid = 1'b0;
    buf_full  = 4'd0;
  endtask

  // One transmit slot; got returns the granted index or -1.
  task automatic run_slot(input logic [3:0] emp, input int ack_dly,
                          output int got);
    int idx;
    bit rl;
    int lat;
    logic [3:0] want;
    got = -1;
    buf_empty = emp;
    slot_tick = 1'b1;
    @(posedge clk);
    #1 slot_tick = 1'b0;
    chk("busy_arb", busy, 1);
    model_pick(emp, idx, rl);
    if (idx < 0) begin
      @(posedge clk);
      #1;
      chk("empty_no_req", rd_req, 0);
      chk("empty_idle", busy, 0);
      return;
    end
    want = 4'b0001 << idx;
    lat = 0;
    while (rd_req == 4'd0 && lat < 6) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("grant", rd_req, want);
    chk("grant_lat", lat, rl ? 2 : 1);
    for (int i = 0; i < 4; i++)
      if (rd_req[i]) got = i;
    for (int d = 0; d < ack_dly; d++) begin
      buf_empty = 4'($urandom);
      slot_tick = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("req_hold", rd_req, want);
      chk("busy_read", busy, 1);
    end
    rd_ack = 1'b1;
    exp_active = 1;
    exp_idx = idx;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    slot_tick = 1'b0;
    exp_active = 0;
    chk("req_drop", rd_req, 0);
    chk("busy_done", busy, 0);
    model_serve(idx);
  endtask

`ifdef QOS_STRICT_PRIORITY_EN
  int exp_order [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int exp_order [11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0};
`endif

  initial begin
    int g;
    logic [3:0] emp;

    do_reset();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    check_counters("rst");

    run_slot(4'b1110, 0, g);
    chk("first_grant_bf1", g, 0);
    @(posedge clk);
    #1;
    check_counters("first");
    chk("bf1_read_one", rdc[0], 1);

    do_reset();
    for (int s = 0; s < 11; s++) begin
      run_slot(4'b0000, 0, g);
      chk($sformatf("order_%0d", s), g, exp_order[s]);
    end
    check_counters("order");

`ifdef QOS_STRICT_PRIORITY_EN
    for (int s = 0; s < 5; s++) begin
      run_slot(4'b0110, 1, g);
      chk($sformatf("strict_%0d", s), g, 0);
    end
`endif

    do_reset();
    repeat (3) arrive(2, 4'b0100);
    @(posedge clk);
    #1;
    chk("bf3_total_3", tot[2], 3);
    chk("bf3_drop_3", drp[2], 3);
    check_counters("bf3_drop");

    repeat (120) arrive(1, 4'b0000);
    @(posedge clk);
    #1;
    chk("bf2_total_sat", tot[1], CMAX);
    check_counters("sat");
    arr_valid = 1'b1;
    arr_id = 2'd1;
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    arr_valid = 1'b0;
    stats_clr = 1'b0;
    chk("bf2_clr_wins", tot[1], 0);
    check_counters("clr");

    run_slot(4'hf, 0, g);
    chk("empty_slot", g, -1);

    arrive(0, 4'b0001);
    arrive(3, 4'b0000);
    buf_empty = 4'b1110;
    slot_tick = 1'b1;
    @(posedge clk);
    #1 slot_tick = 1'b0;
    @(posedge clk);
    #1;
    chk("req_before_rst", rd_req, 4'b0001);
    chk("cnt_before_rst", drp[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", rd_req, 0);
    chk("rst_async_busy", busy, 0);
    check_counters("async_rst");
    for (int i = 0; i < 4; i++) credit[i] = weight[i];
    ptr = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    rand_en = 1;
    for (int s = 0; s < 150; s++) begin
      emp = ($urandom_range(0, 7) == 0) ? 4'hf : 4'($urandom);
      run_slot(emp, $urandom_range(0, 3), g);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      check_counters("rand");
    end
    rand_en = 0;
    @(posedge clk);
    #2;
    arr_valid = 0;
    stats_clr = 0;
    buf_full = 0;
    @(posedge clk);
    #1;
    check_counters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qos_scheduler.md
# qos_scheduler

Output scheduler and statistics keeper for the four QoS packet buffers (bf1..bf4). On each transmit slot it picks one non-empty buffer by weighted round-robin, runs a request/acknowledge read with that buffer, and maintains the per-buffer dropped/total/read counters that the VGA statistics table displays. It sits between the buffer array and the output port, in the `F25MHZ` domain.

## Interface
Parameters:
- `W1`, default 4: WRR weight of bf1 (reads per round), 1..15.
- `W2`, default 3: WRR weight of bf2.
- `W3`, default 2: WRR weight of bf3.
- `W4`, default 1: WRR weight of bf4.
- `CNT_MAX`, default 99: saturation value of every statistics counter (two display digits).

Ports:
- `F25MHZ` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `slot_tick` in 1: one-cycle pulse opening a transmit slot.
- `arr_valid` in 1: a packet arrives this cycle.
- `arr_id` in 2: target buffer of the arrival (0 = bf1 .. 3 = bf4).
- `buf_full` in 4: bit i high means buffer i+1 is full.
- `buf_empty` in 4: bit i high means buffer i+1 is empty.
- `rd_ack` in 1: buffer has delivered the requested packet.
- `stats_clr` in 1: synchronous clear of all counters.
- `rd_req` out 4: one-hot read request, held until `rd_ack`.
- `busy` out 1: high while not in IDLE.
- `bf1_dropped`..`bf4_dropped` out 8 each: arrivals discarded because the target buffer was full.
- `bf1_total`..`bf4_total` out 8 each: all arrivals, dropped ones included.
- `bf1_read`..`bf4_read` out 8 each: completed reads.

## Operation
- FSM states are IDLE, ARB and READ.
- IDLE: when `slot_tick` is high, go to ARB. Otherwise stay.
- ARB, candidate search: scan indices `ptr`, `ptr+1`, … mod 4. The candidate is the first buffer that is not empty and has `credit > 0`.
  - If a candidate is found, register a one-hot `rd_req` and go to READ.
  - If there is no candidate but some buffer is non-empty, reload every credit to its weight and stay in ARB for one cycle.
  - If all buffers are empty, return to IDLE. The slot is lost.
- READ: hold `rd_req` until `rd_ack` is high, even if `buf_empty` changes in the meantime. On `rd_ack`:
  - clear `rd_req`;
  - decrement the served buffer's credit;
  - if that credit becomes 0, set `ptr` to the served index + 1;
  - return to IDLE.
- `slot_tick` outside IDLE is ignored.
- Counters:
  - On `arr_valid`, increment `total[arr_id]`.
  - If `arr_valid` and `buf_full[arr_id]` are both high, also increment `dropped[arr_id]`.
  - `read[i]` increments when `rd_ack` is high while `rd_req[i]` is high.
  - All counters saturate at `CNT_MAX` and never wrap.
- Simultaneous events: an arrival and a read on the same buffer in the same cycle update their separate counters independently. If `stats_clr` coincides with any increment, the clear wins and the counter is 0.
- `stats_clr` does not affect the FSM, the credits or `ptr`.
- Reset mid-operation: `rd_req` drops immediately, and all state is cleared asynchronously.

## Timing
- Reset values:
  - state IDLE;
  - `rd_req` = 0, `busy` = 0;
  - all counters 0;
  - `ptr` = 0;
  - credits = W1..W4.
- Tick sampled at edge k gives ARB from k; `rd_req` is visible after edge k+1 (2-cycle latency), assuming a candidate exists without a reload. A credit reload adds one cycle.
- `rd_ack` sampled at edge m: `rd_req` is low after m, and the `read` counter is updated after m. The earliest next `rd_req` is after m+2, given a tick at m+1.
- Counter outputs are registered and reflect an event one cycle after it.
- All outputs are registers. There are no combinational input-to-output paths.

## Configuration
- `QOS_STRICT_PRIORITY_EN` defined:
  - ARB picks the lowest-index non-empty buffer (bf1 highest priority).
  - Credits and `ptr` are not implemented. Weight parameters are accepted but unused.
  - No reload cycle is ever taken.
- Not defined: weighted round-robin exactly as described under Operation.

## Structure
- Shared package `qos_pkg`:
  - FSM state enum;
  - `NUM_BUF` = 4;
  - counter width 8;
  - `CNT_MAX` default;
  - buffer-index type (2 bits).
- One natural sub-module, `qos_stat_counter`: 8-bit saturating counter with `inc` and `clr` inputs. It is instantiated 12 times.
- The arbiter/FSM stays in the top module.

## Test plan
- Reset released, `bf1` non-empty, tick: `rd_req` = 4'b0001 two cycles later. Ack → `bf1_read` = 1, `busy` = 0.
- All four buffers non-empty, 10 ticks, each acked after 1 cycle: grant order bf1×4, bf2×3, bf3×2, bf4×1; then a credit reload on the 11th tick, with bf1 served again.
- `arr_valid` with `arr_id` = 2 and `buf_full` = 4'b0100, 3 times: `bf3_total` = 3, `bf3_dropped` = 3. Other counters stay 0.
- 120 arrivals to bf2: `bf2_total` saturates at 99. Then `stats_clr` together with a further arrival: `bf2_total` = 0.
- Tick with all buffers empty: ARB lasts one cycle, no `rd_req`, back to IDLE. `rst_n` asserted while `rd_req` is held without ack: `rd_req` = 0 at once, and all counters are 0.
- With `QOS_STRICT_PRIORITY_EN`, bf1 and bf4 non-empty, 5 ticks: bf1 is granted all 5 times.
